// File: rtl/isp_tpsram_fifo_ctrl_if.sv
// isp_tpsram_fifo_ctrl_if: byte stream, RAM port and status signals of the ISP TPSRAM FIFO controller
interface isp_tpsram_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] RAM_WD;
  logic [ADDR_W-1:0] RAM_WADDR;
  logic              RAM_WEN;
  logic [ADDR_W-1:0] RAM_RADDR;
  logic              RAM_REN;
  logic [DATA_W-1:0] RAM_RD;
  logic [ADDR_W:0]   LEVEL;
  logic              ALMOST_FULL;
  modport master (
    input  IN_DATA, IN_VALID, OUT_READY, RAM_RD,
    output IN_READY, OUT_DATA, OUT_VALID, RAM_WD, RAM_WADDR, RAM_WEN, RAM_RADDR, RAM_REN, LEVEL, ALMOST_FULL
  );
  modport slave (
    output IN_DATA, IN_VALID, OUT_READY, RAM_RD,
    input  IN_READY, OUT_DATA, OUT_VALID, RAM_WD, RAM_WADDR, RAM_WEN, RAM_RADDR, RAM_REN, LEVEL, ALMOST_FULL
  );
endinterface

// File: rtl/isp_tpsram_fifo_ctrl.sv
// isp_tpsram_fifo_ctrl: writes upstream bytes into a 64x8 TPSRAM and prefetches them into a 2-entry output queue
module isp_tpsram_fifo_ctrl #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 6,
  parameter int AFULL_THRESH = 56
) (
  input logic CLK,
  input logic RESET,
  input logic CLR,
  isp_tpsram_fifo_ctrl_if.master bus
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2 ** ADDR_W);
  localparam logic [PW-1:0] AF = PW'(AFULL_THRESH);
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, ram_cnt, level;
  logic [1:0] occ_q, occ_d, occ_p;
  logic rd_pend_q, rd_pend_d, push, pop, issue;
  logic [DATA_W-1:0] q0_q, q0_d, q1_q, q1_d;
  always_comb begin
    ram_cnt = wptr_q - rptr_q;
    bus.IN_READY = !RESET && !CLR && ram_cnt != DEPTH;
    push = bus.IN_VALID && bus.IN_READY;
    bus.OUT_VALID = !RESET && occ_q != 2'd0;
    pop = bus.OUT_VALID && bus.OUT_READY;
    occ_p = occ_q - {1'b0, pop};
    issue = !RESET && !CLR && rptr_q != wptr_q && (occ_p + {1'b0, rd_pend_q}) <= 2'd1;
    bus.RAM_WEN = push;
    bus.RAM_WD = bus.IN_DATA;
    bus.RAM_WADDR = wptr_q[ADDR_W-1:0];
    bus.RAM_REN = issue;
    bus.RAM_RADDR = rptr_q[ADDR_W-1:0];
    bus.OUT_DATA = q0_q;
    level = RESET ? '0 : ram_cnt + PW'(rd_pend_q) + PW'(occ_q);
    bus.LEVEL = level;
    bus.ALMOST_FULL = level >= AF;
    wptr_d = wptr_q + PW'(push);
    rptr_d = CLR ? wptr_q : rptr_q + PW'(issue);
    rd_pend_d = issue;
    occ_d = CLR ? 2'd0 : occ_p + {1'b0, rd_pend_q};
    q0_d = (rd_pend_q && occ_p == 2'd0) ? bus.RAM_RD : pop ? q1_q : q0_q;
    q1_d = (rd_pend_q && occ_p != 2'd0) ? bus.RAM_RD : q1_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_pend_q <= 1'b0;
      occ_q     <= 2'd0;
      q0_q      <= '0;
      q1_q      <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_pend_q <= rd_pend_d;
      occ_q     <= occ_d;
      q0_q      <= q0_d;
      q1_q      <= q1_d;
    end
  end
endmodule

// File: tb/tb_isp_tpsram_fifo_ctrl.sv
// tb_isp_tpsram_fifo_ctrl: directed and randomized scenarios for the TPSRAM FIFO controller with a behavioural RAM
module tb_isp_tpsram_fifo_ctrl;
  logic CLK = 1'b0;
  logic RESET, CLR;
  int errors = 0;
  int checks = 0;
  logic [7:0] mem [64];
  isp_tpsram_fifo_ctrl_if bus ();
  isp_tpsram_fifo_ctrl dut (.CLK(CLK), .RESET(RESET), .CLR(CLR), .bus(bus));
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    if (bus.RAM_WEN) mem[bus.RAM_WADDR] <= bus.RAM_WD;
    if (bus.RAM_REN) bus.RAM_RD <= mem[bus.RAM_RADDR];
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset;
    RESET = 1'b1;
    CLR = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA = 8'h11;
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.RAM_WEN !== 1'b0) begin errors++; $display("FAIL reset_wen cycle %0d got=%b exp=0", i, bus.RAM_WEN); end
      checks++;
      if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL reset_in_ready cycle %0d got=%b exp=0", i, bus.IN_READY); end
      step();
    end
    RESET = 1'b0;
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL rel_in_ready got=%b exp=1", bus.IN_READY); end
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL rel_out_valid got=%b exp=0", bus.OUT_VALID); end
    checks++;
    if (bus.LEVEL !== 7'd0) begin errors++; $display("FAIL rel_level got=%0d exp=0", bus.LEVEL); end
    checks++;
    if (bus.ALMOST_FULL !== 1'b0) begin errors++; $display("FAIL rel_afull got=%b exp=0", bus.ALMOST_FULL); end
    checks++;
    if (bus.OUT_DATA !== 8'h00) begin errors++; $display("FAIL rel_out_data got=%h exp=00", bus.OUT_DATA); end
  endtask
  task automatic test_single;
    step();
    bus.IN_VALID = 1'b1;
    bus.IN_DATA = 8'hA5;
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.RAM_WEN !== 1'b1) begin errors++; $display("FAIL single_wen got=%b exp=1", bus.RAM_WEN); end
    checks++;
    if (bus.RAM_WADDR !== 6'd0) begin errors++; $display("FAIL single_waddr got=%0d exp=0", bus.RAM_WADDR); end
    step();
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.RAM_REN !== 1'b1) begin errors++; $display("FAIL single_ren got=%b exp=1", bus.RAM_REN); end
    checks++;
    if (bus.RAM_RADDR !== 6'd0) begin errors++; $display("FAIL single_raddr got=%0d exp=0", bus.RAM_RADDR); end
    step();
    @(negedge CLK);
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", bus.OUT_VALID); end
    step();
    @(negedge CLK);
    checks++;
    if (bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", bus.OUT_VALID); end
    checks++;
    if (bus.OUT_DATA !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", bus.OUT_DATA); end
    step();
    @(negedge CLK);
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL single_valid_drop got=%b exp=0", bus.OUT_VALID); end
    checks++;
    if (bus.LEVEL !== 7'd0) begin errors++; $display("FAIL single_level got=%0d exp=0", bus.LEVEL); end
  endtask
  task automatic test_fill;
    int acc = 0;
    int af_level = -1;
    int idx = 0;
    step();
    bus.OUT_READY = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA = 8'h00;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (bus.ALMOST_FULL === 1'b1 && af_level < 0) af_level = int'(bus.LEVEL);
      if (bus.IN_READY === 1'b1) acc++;
      step();
      bus.IN_DATA = 8'(acc);
      bus.IN_VALID = acc <= 8'h50;
    end
    @(negedge CLK);
    checks++;
    if (acc !== 66) begin errors++; $display("FAIL fill_accepted got=%0d exp=66", acc); end
    checks++;
    if (bus.LEVEL !== 7'd66) begin errors++; $display("FAIL fill_level got=%0d exp=66", bus.LEVEL); end
    checks++;
    if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", bus.IN_READY); end
    checks++;
    if (af_level !== 56) begin errors++; $display("FAIL fill_afull_first_level got=%0d exp=56", af_level); end
    checks++;
    if (bus.ALMOST_FULL !== 1'b1) begin errors++; $display("FAIL fill_afull got=%b exp=1", bus.ALMOST_FULL); end
    step();
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 120 && idx < 66; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        checks++;
        if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL drain_in_ready0 got=%b exp=0", bus.IN_READY); end
        checks++;
        if (bus.RAM_REN !== 1'b1) begin errors++; $display("FAIL drain_ren0 got=%b exp=1", bus.RAM_REN); end
      end
      if (i == 1) begin
        checks++;
        if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL drain_in_ready1 got=%b exp=1", bus.IN_READY); end
      end
      if (bus.OUT_VALID === 1'b1) begin
        checks++;
        if (bus.OUT_DATA !== 8'(idx)) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", idx, bus.OUT_DATA, 8'(idx)); end
        idx++;
      end
      step();
    end
    @(negedge CLK);
    checks++;
    if (idx !== 66) begin errors++; $display("FAIL drain_count got=%0d exp=66", idx); end
    checks++;
    if (bus.LEVEL !== 7'd0) begin errors++; $display("FAIL drain_level got=%0d exp=0", bus.LEVEL); end
  endtask
  task automatic test_back_to_back;
    int sent = 0;
    int got = 0;
    int bubbles = 0;
    int in0 = -1;
    int out0 = -1;
    step();
    bus.OUT_READY = 1'b1;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA = 8'h03;
    for (int cyc = 0; cyc < 400 && got < 200; cyc++) begin
      @(negedge CLK);
      if (bus.OUT_VALID === 1'b1) begin
        if (out0 < 0) out0 = cyc;
        checks++;
        if (bus.OUT_DATA !== 8'(got * 7 + 3)) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", got, bus.OUT_DATA, 8'(got * 7 + 3)); end
        got++;
      end else if (got > 0) bubbles++;
      if (bus.IN_VALID === 1'b1 && bus.IN_READY === 1'b1) begin
        if (in0 < 0) in0 = cyc;
        sent++;
      end
      step();
      bus.IN_DATA = 8'(sent * 7 + 3);
      bus.IN_VALID = sent < 200;
    end
    bus.IN_VALID = 1'b0;
    checks++;
    if (got !== 200) begin errors++; $display("FAIL stream_count got=%0d exp=200", got); end
    checks++;
    if (bubbles !== 0) begin errors++; $display("FAIL stream_bubbles got=%0d exp=0", bubbles); end
    checks++;
    if (out0 - in0 !== 3) begin errors++; $display("FAIL stream_latency got=%0d exp=3", out0 - in0); end
  endtask
  task automatic test_random;
    logic [7:0] exp_q [$];
    logic [7:0] hold_data = 8'h00;
    logic hold = 1'b0;
    int sent = 0;
    int got = 0;
    int coll = 0;
    int unstable = 0;
    step();
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b0;
    for (int cyc = 0; cyc < 8000 && got < 1000; cyc++) begin
      @(negedge CLK);
      if (hold && (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== hold_data)) unstable++;
      hold = bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b0;
      hold_data = bus.OUT_DATA;
      if (bus.RAM_REN === 1'b1 && bus.RAM_WEN === 1'b1 && bus.RAM_RADDR === bus.RAM_WADDR) coll++;
      if (bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_extra_pop[%0d] got=%h exp=none", got, bus.OUT_DATA); end
        else if (bus.OUT_DATA !== exp_q[0]) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", got, bus.OUT_DATA, exp_q[0]); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (bus.IN_VALID === 1'b1 && bus.IN_READY === 1'b1) begin
        exp_q.push_back(bus.IN_DATA);
        sent++;
      end
      step();
      bus.IN_DATA = 8'($urandom);
      bus.IN_VALID = sent < 1000 && $urandom_range(0, 9) < 6;
      bus.OUT_READY = $urandom_range(0, 9) < 6;
    end
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    checks++;
    if (got !== 1000) begin errors++; $display("FAIL rand_count got=%0d exp=1000", got); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
    checks++;
    if (coll !== 0) begin errors++; $display("FAIL rand_collision got=%0d exp=0", coll); end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL rand_hold_stable got=%0d exp=0", unstable); end
    checks++;
    if (bus.LEVEL !== 7'd0) begin errors++; $display("FAIL rand_level got=%0d exp=0", bus.LEVEL); end
  endtask
  task automatic test_clr;
    step();
    bus.OUT_READY = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA = 8'h77;
    @(negedge CLK);
    step();
    bus.IN_DATA = 8'h78;
    @(negedge CLK);
    checks++;
    if (bus.RAM_REN !== 1'b1) begin errors++; $display("FAIL clr_setup_ren got=%b exp=1", bus.RAM_REN); end
    step();
    CLR = 1'b1;
    bus.IN_DATA = 8'h99;
    @(negedge CLK);
    checks++;
    if (bus.LEVEL !== 7'd2) begin errors++; $display("FAIL clr_pre_level got=%0d exp=2", bus.LEVEL); end
    checks++;
    if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL clr_in_ready got=%b exp=0", bus.IN_READY); end
    checks++;
    if (bus.RAM_REN !== 1'b0) begin errors++; $display("FAIL clr_ren got=%b exp=0", bus.RAM_REN); end
    checks++;
    if (bus.RAM_WEN !== 1'b0) begin errors++; $display("FAIL clr_wen got=%b exp=0", bus.RAM_WEN); end
    step();
    CLR = 1'b0;
    bus.IN_DATA = 8'h3C;
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL clr_out_valid got=%b exp=0", bus.OUT_VALID); end
    checks++;
    if (bus.LEVEL !== 7'd0) begin errors++; $display("FAIL clr_level got=%0d exp=0", bus.LEVEL); end
    checks++;
    if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL clr_post_in_ready got=%b exp=1", bus.IN_READY); end
    step();
    bus.IN_VALID = 1'b0;
    for (int i = 1; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL clr_wait_valid c+%0d got=%b exp=0", i, bus.OUT_VALID); end
      step();
    end
    @(negedge CLK);
    checks++;
    if (bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL clr_new_valid got=%b exp=1", bus.OUT_VALID); end
    checks++;
    if (bus.OUT_DATA !== 8'h3C) begin errors++; $display("FAIL clr_new_data got=%h exp=3c", bus.OUT_DATA); end
    step();
    @(negedge CLK);
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL clr_end_valid got=%b exp=0", bus.OUT_VALID); end
    checks++;
    if (bus.LEVEL !== 7'd0) begin errors++; $display("FAIL clr_end_level got=%0d exp=0", bus.LEVEL); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_random();
    test_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/isp_tpsram_fifo_ctrl.md
Name: isp_tpsram_fifo_ctrl

Overview:
- FIFO controller that drives the 64x8 two-port LSRAM buffer (TPSRAM, one clock, synchronous read, 1-cycle read latency) from the ISP restart path.
- Accepts programming-image bytes from the upstream byte source over a valid/ready handshake.
- Writes them to the RAM and prefetches them back into a 2-entry registered output queue feeding the downstream ISP engine.
- The RAM is instantiated outside this block; this block owns all RAM address, enable and data signals.

Parameters:
- DATA_W, 8, byte width; equals RAM data width.
- ADDR_W, 6, RAM address width; RAM depth = 2**ADDR_W = 64.
- AFULL_THRESH, 56, LEVEL value at or above which ALMOST_FULL asserts.

Ports:
- CLK  in  1  single clock, shared with the RAM.
- RESET  in  1  synchronous, active-high reset.
- CLR  in  1  synchronous flush; RAM contents left untouched.
- IN_DATA  in  DATA_W  byte from upstream.
- IN_VALID  in  1  upstream byte valid.
- IN_READY  out  1  block accepts the byte this cycle.
- OUT_DATA  out  DATA_W  head byte to downstream, registered.
- OUT_VALID  out  1  OUT_DATA valid, registered.
- OUT_READY  in  1  downstream consumes the head byte.
- RAM_WD  out  DATA_W  RAM write data.
- RAM_WADDR  out  ADDR_W  RAM write address.
- RAM_WEN  out  1  RAM write enable, active high.
- RAM_RADDR  out  ADDR_W  RAM read address.
- RAM_REN  out  1  RAM read enable, active high.
- RAM_RD  in  DATA_W  RAM read data, valid the cycle after RAM_REN.
- LEVEL  out  ADDR_W+1  bytes held: RAM + in-flight + output queue, range 0..66.
- ALMOST_FULL  out  1  LEVEL >= AFULL_THRESH.

Behaviour:
- Pointers: wptr and rptr are ADDR_W+1 bits.
  - RAM addresses are the low ADDR_W bits; wrap 63->0.
  - ram_cnt = wptr - rptr, range 0..64.
- Reset (RESET=1 at an edge): wptr, rptr, rd_pend and out_occ clear; OUT_DATA=0.
  - While RESET is high: OUT_VALID=0, IN_READY=0, RAM_WEN=0, RAM_REN=0, LEVEL=0, ALMOST_FULL=0.
  - IN_READY=1 in the first cycle after RESET deasserts.
- Push: IN_READY = !RESET && !CLR && (ram_cnt != 64).
  - On IN_VALID&&IN_READY, combinationally in the same cycle: RAM_WEN=1, RAM_WD=IN_DATA, RAM_WADDR=wptr[5:0].
  - wptr increments at that edge.
- Read issue: issue = (rptr != wptr) && (out_occ + rd_pend - pop) <= 1, where pop = OUT_VALID&&OUT_READY.
  - Uses the registered wptr, so a byte written at edge N is readable no earlier than the cycle after edge N. This guarantees no same-address read/write collision.
  - issue drives RAM_REN=1 and RAM_RADDR=rptr[5:0]; rptr increments; rd_pend <= issue.
  - RAM_RD is sampled only when rd_pend=1; it is never relied on otherwise.
- Output queue: 2 entries, in order.
  - Captures RAM_RD when rd_pend=1. Pop removes the head.
  - Capture and pop in the same cycle are both honoured.
  - OUT_DATA and OUT_VALID are stable while OUT_VALID && !OUT_READY.
- Latency and throughput:
  - Input handshake in cycle c into an empty block gives OUT_VALID=1 in cycle c+3.
  - Sustained rate is 1 byte/cycle with both sides ready.
- Full:
  - With OUT_READY held 0, the block absorbs 66 bytes: 2 in the queue, 64 in RAM.
  - A RAM read frees space one cycle later; IN_READY rises in the cycle after the freeing issue.
- Empty: OUT_VALID=0 when out_occ=0. A pop with OUT_VALID=0 is ignored.
- LEVEL = ram_cnt + rd_pend + out_occ, a function of registered state only. ALMOST_FULL is combinational from LEVEL.
- CLR (synchronous):
  - Sets rptr <= wptr, clears out_occ and rd_pend; discards any in-flight read.
  - During the CLR cycle: IN_READY=0, no issue, RAM_WEN=0.
  - Next cycle: OUT_VALID=0 and LEVEL=0.
- RESET has priority over CLR.

Test Plan:
- Reset: hold RESET 3 cycles with IN_VALID=1 -> no RAM_WEN; after release IN_READY=1, OUT_VALID=0, LEVEL=0, ALMOST_FULL=0.
- Single byte: push 0xA5 in cycle c, OUT_READY=1 ->
  - RAM_WEN=1, RAM_WADDR=0 in cycle c; RAM_REN=1, RAM_RADDR=0 in c+1;
  - OUT_VALID=1, OUT_DATA=0xA5 in c+3 for one cycle; LEVEL returns to 0.
- Fill: OUT_READY=0, push 0x00..0x50 continuously ->
  - exactly 66 accepted (0x00..0x41), then IN_READY=0;
  - LEVEL=66; ALMOST_FULL first seen when LEVEL=56;
  - drain yields 0x00..0x41 in order, and IN_READY returns after the first RAM read.
- Stream: 200 bytes, both sides always ready ->
  - after 3-cycle fill, one byte/cycle with no bubble; pointers wrap 3 times; output in order.
- Random backpressure: 1000 random bytes, random IN_VALID and OUT_READY ->
  - in-order, no loss or duplication;
  - never RAM_REN and RAM_WEN in the same cycle with equal addresses while that address holds unread data.
- CLR with a read in flight ->
  - next cycle OUT_VALID=0, LEVEL=0;
  - next pushed byte 0x3C appears on OUT_DATA 3 cycles after its handshake.
